// File: rtl/axil_rd_slave_if.sv
// AXI4-Lite read channel plus single-beat backend request/response port.
// "slave" is the read-slave view; "master" is the surrounding master and backend.
interface axil_rd_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0] ar_addr;
  logic [2:0]        ar_prot;
  logic              ar_valid;
  logic              ar_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_valid;
  logic              r_ready;
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_ready;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              mem_rsp_err;

  modport slave (
    input  ar_addr, ar_prot, ar_valid, r_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    output ar_ready, r_data, r_resp, r_valid,
    output mem_req_valid, mem_req_addr
  );

  modport master (
    output ar_addr, ar_prot, ar_valid, r_ready,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    input  ar_ready, r_data, r_resp, r_valid,
    input  mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/axil_rd_slave.sv
// AXI4-Lite read slave: windowed decode, one outstanding backend request with
// timeout, and a one-deep pending address buffer while a response is stalled.
//   state | meaning
//   IDLE  | waiting for an address
//   REQ   | backend request presented, waiting for mem_req_ready
//   WAIT  | waiting for backend data or timeout
//   RESP  | response presented, waiting for r_ready
module axil_rd_slave #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(32'h8000_0000),
  parameter logic [ADDR_W-1:0] SIZE_BYTES = ADDR_W'(32'h0800_0000),
  parameter bit                PRIV_ONLY  = 1'b0,
  parameter int                TIMEOUT    = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  axil_rd_slave_if.slave bus
);

  localparam int LSB_W = $clog2(DATA_W / 8);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // One extra bit keeps a window that ends exactly at 2^ADDR_W from wrapping.
  localparam logic [ADDR_W:0] C_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] C_HI = {1'b0, BASE_ADDR} + {1'b0, SIZE_BYTES};

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  logic              r_pend_valid;
  logic [ADDR_W-1:0] r_pend_addr;
  logic              r_pend_prot0;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_r_valid;
  logic [DATA_W-1:0] r_r_data;
  logic [1:0]        r_r_resp;
  logic              r_mem_req_valid;
  logic [ADDR_W-1:0] r_mem_req_addr;

  logic              w_ar_ready;
  logic              w_ar_hs;
  logic              w_r_hs;
  logic              w_nxt_go;
  logic [ADDR_W-1:0] w_nxt_addr;
  logic              w_nxt_prot0;
  logic [1:0]        w_ar_dec;
  logic [1:0]        w_nxt_dec;
  logic              w_unused;

  function automatic logic [1:0] f_decode(input logic [ADDR_W-1:0] addr, input logic prot0);
    logic [ADDR_W:0] a_ext;
    a_ext = {1'b0, addr};
    if (a_ext < C_LO || a_ext >= C_HI) return RESP_DECERR;
    if (addr[LSB_W-1:0] != '0) return RESP_SLVERR;
    if (PRIV_ONLY && !prot0) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  assign w_ar_ready  = rst_n && (r_state == S_IDLE || (r_state == S_RESP && !r_pend_valid));
  assign w_ar_hs     = bus.ar_valid && w_ar_ready;
  assign w_r_hs      = r_r_valid && bus.r_ready;
  assign w_ar_dec    = f_decode(bus.ar_addr, bus.ar_prot[0]);
  // Pending entry always wins; otherwise a same-cycle AR handshake is taken.
  assign w_nxt_go    = r_pend_valid || w_ar_hs;
  assign w_nxt_addr  = r_pend_valid ? r_pend_addr  : bus.ar_addr;
  assign w_nxt_prot0 = r_pend_valid ? r_pend_prot0 : bus.ar_prot[0];
  assign w_nxt_dec   = f_decode(w_nxt_addr, w_nxt_prot0);
  assign w_unused    = ^bus.ar_prot[2:1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_pend_valid    <= 1'b0;
      r_pend_addr     <= '0;
      r_pend_prot0    <= 1'b0;
      r_cnt           <= '0;
      r_r_valid       <= 1'b0;
      r_r_data        <= '0;
      r_r_resp        <= RESP_OKAY;
      r_mem_req_valid <= 1'b0;
      r_mem_req_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ar_hs) begin
            if (w_ar_dec == RESP_OKAY) begin
              r_state         <= S_REQ;
              r_mem_req_valid <= 1'b1;
              r_mem_req_addr  <= bus.ar_addr;
            end else begin
              r_state   <= S_RESP;
              r_r_valid <= 1'b1;
              r_r_data  <= '0;
              r_r_resp  <= w_ar_dec;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_req_ready) begin
            r_state         <= S_WAIT;
            r_mem_req_valid <= 1'b0;
            r_cnt           <= '0;
          end
        end
        S_WAIT: begin
          if (bus.mem_rsp_valid) begin
            r_state   <= S_RESP;
            r_r_valid <= 1'b1;
            r_r_data  <= bus.mem_rsp_data;
            r_r_resp  <= bus.mem_rsp_err ? RESP_SLVERR : RESP_OKAY;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_state   <= S_RESP;
            r_r_valid <= 1'b1;
            r_r_data  <= '0;
            r_r_resp  <= RESP_SLVERR;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (w_r_hs) begin
            if (w_nxt_go) begin
              r_pend_valid <= 1'b0;
              if (w_nxt_dec == RESP_OKAY) begin
                r_state         <= S_REQ;
                r_r_valid       <= 1'b0;
                r_mem_req_valid <= 1'b1;
                r_mem_req_addr  <= w_nxt_addr;
              end else begin
                r_state  <= S_RESP;
                r_r_data <= '0;
                r_r_resp <= w_nxt_dec;
              end
            end else begin
              r_state   <= S_IDLE;
              r_r_valid <= 1'b0;
            end
          end else if (w_ar_hs) begin
            r_pend_valid <= 1'b1;
            r_pend_addr  <= bus.ar_addr;
            r_pend_prot0 <= bus.ar_prot[0];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ar_ready      = w_ar_ready;
  assign bus.r_valid       = r_r_valid;
  assign bus.r_data        = r_r_data;
  assign bus.r_resp        = r_r_resp;
  assign bus.mem_req_valid = r_mem_req_valid;
  assign bus.mem_req_addr  = r_mem_req_addr;

endmodule

// File: tb/tb_axil_rd_slave.sv
// Self-checking bench for axil_rd_slave: directed corner cases plus randomized
// reads checked against an arithmetic model of the address window.
module tb_axil_rd_slave;
  localparam int          ADDR_W  = 32;
  localparam int          DATA_W  = 64;
  localparam int          TIMEOUT = 8;
  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam logic [31:0] SIZE    = 32'h0800_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  axil_rd_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axil_rd_slave #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE), .SIZE_BYTES(SIZE),
    .PRIV_ONLY(1'b0), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference decode from the window rules, in plain 64-bit arithmetic.
  function automatic logic [1:0] model_resp(input logic [31:0] a);
    longint unsigned ai, lo, hi;
    ai = 64'(a);
    lo = 64'(BASE);
    hi = 64'(BASE) + 64'(SIZE);
    if (ai < lo || ai >= hi) return 2'b11;
    if (ai % 8 != 0) return 2'b10;
    return 2'b00;
  endfunction

  task automatic do_read(input logic [31:0] a, input int rdy_dly, input int rsp_dly,
                         input bit err, input bit silent, input int stall,
                         input logic [63:0] d);
    logic [1:0]  er;
    logic [63:0] ed;
    int          k;
    er = model_resp(a);
    ed = '0;
    check_eq("ar_ready_idle", 128'(bus.ar_ready), 128'(1));
    bus.ar_valid = 1'b1;
    bus.ar_addr  = a;
    bus.ar_prot  = 3'($urandom_range(0, 7));
    step();
    bus.ar_valid = 1'b0;
    if (er != 2'b00) begin
      check_eq("err_no_req", 128'(bus.mem_req_valid), 128'(0));
    end else begin
      check_eq("req_valid", 128'(bus.mem_req_valid), 128'(1));
      check_eq("req_addr", 128'(bus.mem_req_addr), 128'(a));
      repeat (rdy_dly) step();
      check_eq("req_hold", 128'({bus.mem_req_valid, bus.mem_req_addr}), 128'({1'b1, a}));
      bus.mem_req_ready = 1'b1;
      step();
      bus.mem_req_ready = 1'b0;
      check_eq("req_drop", 128'(bus.mem_req_valid), 128'(0));
      if (silent) begin
        k = 0;
        while (!bus.r_valid && k < TIMEOUT + 4) begin
          step();
          k++;
        end
        check_eq("timeout_cycles", 128'(k), 128'(TIMEOUT));
        er = 2'b10;
      end else begin
        repeat (rsp_dly) step();
        check_eq("no_early_rvalid", 128'(bus.r_valid), 128'(0));
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = d;
        bus.mem_rsp_err   = err;
        step();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.mem_rsp_err   = 1'b0;
        er = err ? 2'b10 : 2'b00;
        ed = d;
      end
    end
    check_eq("r_valid", 128'(bus.r_valid), 128'(1));
    check_eq("r_resp", 128'(bus.r_resp), 128'(er));
    check_eq("r_data", 128'(bus.r_data), 128'(ed));
    repeat (stall) begin
      step();
      check_eq("r_stall", 128'({bus.r_valid, bus.r_resp, bus.r_data}), 128'({1'b1, er, ed}));
    end
    bus.r_ready = 1'b1;
    step();
    bus.r_ready = 1'b0;
    check_eq("r_done", 128'(bus.r_valid), 128'(0));
    if (silent) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = d;
      step();
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
      check_eq("late_ignored", 128'({bus.r_valid, bus.mem_req_valid}), 128'(0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [31:0] errs [4];
    logic [63:0] d;
    int          mode;

    bus.ar_valid      = 1'b0;
    bus.ar_addr       = '0;
    bus.ar_prot       = '0;
    bus.r_ready       = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.mem_rsp_err   = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    check_eq("rst_ar_ready", 128'(bus.ar_ready), 128'(0));
    check_eq("rst_r_valid", 128'(bus.r_valid), 128'(0));
    check_eq("rst_r_data", 128'(bus.r_data), 128'(0));
    check_eq("rst_r_resp", 128'(bus.r_resp), 128'(0));
    check_eq("rst_req_valid", 128'(bus.mem_req_valid), 128'(0));
    check_eq("rst_req_addr", 128'(bus.mem_req_addr), 128'(0));
    rst_n = 1'b1;
    step();

    // Minimum-latency read, then reset while the next one is in WAIT.
    do_read(32'h8000_0010, 0, 0, 1'b0, 1'b0, 0, 64'hDEAD_BEEF_0123_4567);
    bus.ar_valid = 1'b1;
    bus.ar_addr  = 32'h8000_0080;
    step();
    bus.ar_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    rst_n = 1'b0;
    step();
    check_eq("midrst_outputs",
             128'({bus.ar_ready, bus.r_valid, bus.r_resp, bus.mem_req_valid, bus.mem_req_addr, bus.r_data}),
             128'(0));
    rst_n = 1'b1;
    step();
    check_eq("midrst_idle", 128'({bus.ar_ready, bus.r_valid}), 128'({1'b1, 1'b0}));

    do_read(32'h7FFF_FFF8, 0, 0, 1'b0, 1'b0, 0, 64'h0);
    do_read(32'h8000_0004, 0, 0, 1'b0, 1'b0, 1, 64'h0);
    do_read(32'h8000_0020, 1, 2, 1'b1, 1'b0, 0, 64'h1111_2222_3333_4444);
    do_read(32'h8000_0030, 0, 0, 1'b0, 1'b1, 0, 64'hBAD0_BAD0_BAD0_BAD0);
    do_read(32'h8000_0040, 0, 0, 1'b0, 1'b0, 0, 64'h0BAD_F00D_CAFE_0042);
    do_read(32'h87FF_FFF8, 0, 1, 1'b0, 1'b0, 0, 64'h5555_AAAA_5555_AAAA);
    do_read(32'h8800_0000, 0, 0, 1'b0, 1'b0, 0, 64'h0);

    // Stalled response with a second address buffered and a third held off.
    bus.ar_valid = 1'b1;
    bus.ar_addr  = 32'h8000_0100;
    step();
    bus.ar_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 64'hAAAA_0000_0000_0100;
    step();
    bus.mem_rsp_valid = 1'b0;
    check_eq("pend_a_data", 128'(bus.r_data), 128'(64'hAAAA_0000_0000_0100));
    check_eq("pend_room", 128'(bus.ar_ready), 128'(1));
    bus.ar_valid = 1'b1;
    bus.ar_addr  = 32'h8000_0200;
    step();
    check_eq("pend_full", 128'(bus.ar_ready), 128'(0));
    bus.ar_addr = 32'h7000_0000;
    repeat (4) begin
      step();
      check_eq("pend_stall",
               128'({bus.ar_ready, bus.r_valid, bus.r_resp, bus.r_data}),
               128'({1'b0, 1'b1, 2'b00, 64'hAAAA_0000_0000_0100}));
    end
    bus.r_ready = 1'b1;
    step();
    bus.r_ready = 1'b0;
    check_eq("pend_b_req",
             128'({bus.r_valid, bus.mem_req_valid, bus.mem_req_addr}),
             128'({1'b0, 1'b1, 32'h8000_0200}));
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 64'hBBBB_0000_0000_0200;
    step();
    bus.mem_rsp_valid = 1'b0;
    check_eq("pend_b_rsp",
             128'({bus.r_valid, bus.r_resp, bus.r_data}),
             128'({1'b1, 2'b00, 64'hBBBB_0000_0000_0200}));
    bus.r_ready = 1'b1;
    step();
    bus.ar_valid = 1'b0;
    check_eq("pend_c_rsp",
             128'({bus.r_valid, bus.r_resp, bus.r_data}),
             128'({1'b1, model_resp(32'h7000_0000), 64'h0}));
    step();
    bus.r_ready = 1'b0;
    check_eq("pend_done", 128'(bus.r_valid), 128'(0));

    // Back-to-back error responses, one per cycle.
    errs[0] = 32'h7FFF_FFF8;
    errs[1] = 32'h8000_0004;
    errs[2] = 32'h8800_0000;
    errs[3] = 32'h8000_0001;
    bus.r_ready  = 1'b1;
    bus.ar_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ar_addr = errs[i];
      step();
      check_eq("b2b_rsp", 128'({bus.r_valid, bus.r_resp, bus.r_data}),
               128'({1'b1, model_resp(errs[i]), 64'h0}));
    end
    bus.ar_valid = 1'b0;
    step();
    bus.r_ready = 1'b0;
    check_eq("b2b_done", 128'(bus.r_valid), 128'(0));

    for (int n = 0; n < 40; n++) begin
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: a = BASE + ($urandom_range(0, (SIZE / 8) - 1) * 8);
        1: a = BASE + ($urandom_range(0, (SIZE / 8) - 1) * 8) + $urandom_range(1, 7);
        2: a = $urandom_range(0, BASE - 1);
        default: a = BASE + SIZE + $urandom_range(0, 32'h0000_1000);
      endcase
      d = {$urandom, $urandom};
      do_read(a, int'($urandom_range(0, 3)), int'($urandom_range(0, TIMEOUT - 3)),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
              int'($urandom_range(0, 3)), d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
